// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified IF/MEM memory arbiter.
package mem_arb_pkg;

  // Transaction sequencer states: accept, wait out the memory latency, report.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

  // Which pipeline stage owns the transaction currently in flight.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    OWN_IF = 2'd1,
    OWN_D  = 2'd2
  } owner_e;

  // Latency counter width; covers memory latencies 1..15.
  localparam int LAT_CNT_W = 4;

  // True when the latency counter has reached the configured memory latency.
  function automatic logic lat_reached(input logic [LAT_CNT_W-1:0] cnt,
                                       input int unsigned           lat);
    logic [LAT_CNT_W-1:0] lat_v;
    lat_v = lat[LAT_CNT_W-1:0];
    return (cnt == lat_v);
  endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating counter of consecutive data grants taken over a waiting fetch.
module starve_counter #(
  parameter int unsigned MAX = 4,
  parameter int unsigned W   = $clog2(MAX + 1)
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_inc,
  input  logic i_clr,
  output logic o_at_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;

  // Clear wins over increment; increment stops once the limit is reached.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      r_cnt <= r_cnt + W'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_at_max = (r_cnt == MAX_V);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port fixed-latency memory between instruction fetch and
// the data load/store stage. One transaction at a time; data has priority,
// but a fetch that has waited through STARVE_MAX data grants is forced in.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_e               r_state;
  state_e               w_state_nxt;
  owner_e               r_owner;
  owner_e               w_owner_nxt;
  logic                 r_we;
  logic                 w_we_nxt;
  logic [LAT_CNT_W-1:0] r_lat_cnt;
  logic [LAT_CNT_W-1:0] w_lat_cnt_nxt;
  logic                 w_capture;

  logic [DATA_W-1:0]    r_if_rdata;
  logic [DATA_W-1:0]    r_d_rdata;
  logic                 r_if_rvalid;
  logic                 r_d_rvalid;

  logic                 w_if_gnt;
  logic                 w_d_gnt;
  logic                 w_starve_at_max;
  logic                 w_starve_inc;
  logic                 w_starve_clr;

  // Grant selection: only in IDLE and never while reset is asserted.
  always_comb begin
    w_if_gnt = 1'b0;
    w_d_gnt  = 1'b0;
    if (!rst && (r_state == IDLE)) begin
      if (d_req && !(if_req && w_starve_at_max)) begin
        w_d_gnt = 1'b1;
      end else if (if_req) begin
        w_if_gnt = 1'b1;
      end else begin
        w_d_gnt  = 1'b0;
        w_if_gnt = 1'b0;
      end
    end else begin
      w_if_gnt = 1'b0;
      w_d_gnt  = 1'b0;
    end
  end

  // Memory-side mux: drive the granted port's request, zeros when idle.
  always_comb begin
    mem_en    = w_if_gnt | w_d_gnt;
    mem_we    = d_we & w_d_gnt;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_d_gnt) begin
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (w_if_gnt) begin
      mem_addr  = if_addr;
    end else begin
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  // Starvation bookkeeping: a data grant over a waiting fetch counts up;
  // a fetch grant or an absent fetch request resets the run.
  assign w_starve_inc = w_d_gnt & if_req;
  assign w_starve_clr = w_if_gnt | ~if_req;

  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_inc    (w_starve_inc),
    .i_clr    (w_starve_clr),
    .o_at_max (w_starve_at_max)
  );

  // Next-state logic for the accept / wait-latency / report sequence.
  always_comb begin
    w_state_nxt   = r_state;
    w_owner_nxt   = r_owner;
    w_we_nxt      = r_we;
    w_lat_cnt_nxt = r_lat_cnt;
    w_capture     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_if_gnt || w_d_gnt) begin
          w_state_nxt   = WAIT;
          w_owner_nxt   = w_d_gnt ? OWN_D : OWN_IF;
          w_we_nxt      = w_d_gnt & d_we;
          w_lat_cnt_nxt = LAT_CNT_W'(1);
        end else begin
          w_owner_nxt   = NONE;
          w_we_nxt      = 1'b0;
        end
      end
      WAIT: begin
        if (lat_reached(r_lat_cnt, MEM_LAT)) begin
          w_state_nxt = DONE;
          w_capture   = 1'b1;
        end else begin
          w_lat_cnt_nxt = r_lat_cnt + LAT_CNT_W'(1);
        end
      end
      DONE: begin
        w_state_nxt   = IDLE;
        w_owner_nxt   = NONE;
        w_we_nxt      = 1'b0;
        w_lat_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt   = IDLE;
        w_owner_nxt   = NONE;
        w_we_nxt      = 1'b0;
        w_lat_cnt_nxt = '0;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= NONE;
      r_we      <= 1'b0;
      r_lat_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_owner   <= w_owner_nxt;
      r_we      <= w_we_nxt;
      r_lat_cnt <= w_lat_cnt_nxt;
    end
  end

  // Return path: capture read data for the owner and pulse its rvalid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
    end else begin
      r_if_rvalid <= w_capture && (r_owner == OWN_IF);
      r_d_rvalid  <= w_capture && (r_owner == OWN_D);
      if (w_capture && !r_we && (r_owner == OWN_IF)) begin
        r_if_rdata <= mem_rdata;
      end else if (w_capture && !r_we && (r_owner == OWN_D)) begin
        r_d_rdata  <= mem_rdata;
      end else begin
        r_if_rdata <= r_if_rdata;
        r_d_rdata  <= r_d_rdata;
      end
    end
  end

  assign if_gnt    = w_if_gnt;
  assign d_gnt     = w_d_gnt;
  assign if_rvalid = r_if_rvalid;
  assign d_rvalid  = r_d_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_unified_mem_arbiter;

  localparam int unsigned LAT  = 2;
  localparam int unsigned SMAX = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic        l1_if_req, l1_if_gnt, l1_if_rvalid;
  logic [31:0] l1_if_addr, l1_if_rdata;
  logic        l1_d_req, l1_d_we, l1_d_gnt, l1_d_rvalid;
  logic [31:0] l1_d_addr, l1_d_wdata, l1_d_rdata;
  logic        l1_mem_en, l1_mem_we, l1_busy;
  logic [31:0] l1_mem_addr, l1_mem_wdata, l1_mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  logic [31:0] rd_pipe [0:LAT-1];
  logic [31:0] l1_pipe;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(SMAX)) dut1 (
    .clk(clk), .rst(rst),
    .if_req(l1_if_req), .if_addr(l1_if_addr), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid),
    .if_rdata(l1_if_rdata),
    .d_req(l1_d_req), .d_we(l1_d_we), .d_addr(l1_d_addr), .d_wdata(l1_d_wdata),
    .d_gnt(l1_d_gnt), .d_rvalid(l1_d_rvalid), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  // Power-on content of every memory word (never zero).
  function automatic logic [31:0] init_word(input int unsigned idx);
    return (32'h5A3C_0001 ^ (idx << 8)) | 32'h0000_0001;
  endfunction

  // Behavioural fixed-latency memory: writes land at the strobe, read data
  // emerges LAT cycles later; a poison value fills every other slot.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
    rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[9:2]] : 32'hBAD0_0BAD;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    l1_pipe <= l1_mem_en ? mem[l1_mem_addr[9:2]] : 32'hBAD1_1BAD;
  end
  assign mem_rdata    = rd_pipe[LAT-1];
  assign l1_mem_rdata = l1_pipe;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b1;
    d_addr = 32'h10; d_wdata = 32'h1111_2222;
    l1_if_req = 1'b1; l1_if_addr = 32'h0; l1_d_req = 1'b0; l1_d_we = 1'b0;
    l1_d_addr = 32'h0; l1_d_wdata = 32'h0;
    nxt(); nxt();
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt got=%b exp=0000", {if_gnt, d_gnt, mem_en, mem_we}); end
    checks++; if ({if_rvalid, d_rvalid, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_status got=%b exp=000", {if_rvalid, d_rvalid, busy}); end
    checks++; if ({if_rdata, d_rdata} !== 64'h0) begin
      errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata, d_rdata); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin
      errors++; $display("FAIL reset_membus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    checks++; if ({l1_if_gnt, l1_busy} !== 2'b00) begin
      errors++; $display("FAIL reset_l1 got=%b exp=00", {l1_if_gnt, l1_busy}); end
    nxt();
    rst = 1'b0; idle_inputs(); l1_if_req = 1'b0;
    nxt();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0;
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, mem_en, mem_we, busy} !== 5'b10100 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL fetch_t0 got=%b addr=%h exp=10100 addr=0",
                         {if_gnt, d_gnt, mem_en, mem_we, busy}, mem_addr); end
    nxt();
    if_req = 1'b0; if_addr = 32'hFFFF_FFFC;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      checks++; if ({busy, if_rvalid, if_gnt} !== {(t <= 3), (t == 3), 1'b0}) begin
        errors++; $display("FAIL fetch_t%0d got=%b exp=%b", t, {busy, if_rvalid, if_gnt},
                           {(t <= 3), (t == 3), 1'b0}); end
      if (t == 3) begin
        checks++; if (if_rdata !== init_word(0)) begin
          errors++; $display("FAIL fetch_rdata got=%h exp=%h", if_rdata, init_word(0)); end
      end
      nxt();
    end
  endtask

  task automatic wait_d_load(input logic [31:0] addr, input logic [31:0] expv, input string nm);
    bit found;
    d_req = 1'b1; d_we = 1'b0; d_addr = addr;
    nxt();
    d_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (d_rvalid) found = 1'b1; else nxt();
    end
    checks++; if (!found || d_rdata !== expv) begin
      errors++; $display("FAIL %s found=%0d got=%h exp=%h", nm, found, d_rdata, expv); end
    nxt();
  endtask

  task automatic test_store_then_load();
    bit found;
    wait_d_load(32'h10, init_word(4), "pre_load");
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    if_req = 1'b1; if_addr = 32'h8;
    @(negedge clk);
    checks++; if ({if_gnt, d_gnt, mem_en, mem_we} !== 4'b0111 || mem_addr !== 32'h40 ||
                  mem_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_t0 got=%b %h %h exp=0111 00000040 deadbeef",
                         {if_gnt, d_gnt, mem_en, mem_we}, mem_addr, mem_wdata); end
    nxt();
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      checks++; if ({d_rvalid, if_gnt} !== {(t == 3), (t == 4)}) begin
        errors++; $display("FAIL store_t%0d got=%b exp=%b", t, {d_rvalid, if_gnt}, {(t == 3), (t == 4)}); end
      if (t == 3) begin
        checks++; if (d_rdata !== init_word(4)) begin
          errors++; $display("FAIL store_keeps_rdata got=%h exp=%h", d_rdata, init_word(4)); end
      end
      if (t == 4) begin
        checks++; if (mem_addr !== 32'h8) begin
          errors++; $display("FAIL store_if_addr got=%h exp=00000008", mem_addr); end
      end
      nxt();
    end
    if_req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 8 && !found; k++) begin
      @(negedge clk);
      if (if_rvalid) found = 1'b1; else nxt();
    end
    checks++; if (!found || if_rdata !== init_word(2)) begin
      errors++; $display("FAIL store_if_rdata found=%0d got=%h exp=%h", found, if_rdata, init_word(2)); end
    nxt();
    wait_d_load(32'h40, 32'hDEAD_BEEF, "load_after_store");
  endtask

  task automatic test_starvation();
    bit seq [0:5];
    int gc [0:5];
    int n, ifk;
    bit gap_ok;
    n = 0; ifk = -10;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20; if_req = 1'b1; if_addr = 32'hC;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(negedge clk);
      if (k == ifk + 1) begin
        checks++; if (dut.u_starve.r_cnt !== 3'd0) begin
          errors++; $display("FAIL starve_cleared got=%0d exp=0", dut.u_starve.r_cnt); end
      end
      if (if_gnt || d_gnt) begin
        seq[n] = d_gnt; gc[n] = k;
        if (if_gnt) ifk = k;
        n++;
      end
      if (n < 6) nxt();
    end
    checks++; if (n != 6) begin
      errors++; $display("FAIL starve_count got=%0d exp=6", n); end
    else begin
      checks++; if ({seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]} !== 6'b111101) begin
        errors++; $display("FAIL starve_order got=%b exp=111101",
                           {seq[0], seq[1], seq[2], seq[3], seq[4], seq[5]}); end
      gap_ok = 1'b1;
      for (int i = 0; i < 5; i++) if (gc[i+1] - gc[i] != LAT + 2) gap_ok = 1'b0;
      checks++; if (!gap_ok) begin
        errors++; $display("FAIL starve_spacing got=%0d exp=%0d", gc[1] - gc[0], LAT + 2); end
    end
    nxt();
    idle_inputs();
    for (int k = 0; k < LAT + 3; k++) nxt();
  endtask

  task automatic test_withdrawal();
    int n_dg, n_en, n_drv;
    n_dg = 0; n_en = 0; n_drv = 0;
    if_req = 1'b1; if_addr = 32'h14;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL wd_if_gnt got=%b exp=1", if_gnt); end
    nxt();
    if_req = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_dg += int'(d_gnt); n_en += int'(mem_en); n_drv += int'(d_rvalid);
      nxt();
      if (k == 0) idle_inputs();
    end
    checks++; if (n_dg != 0 || n_en != 0 || n_drv != 0) begin
      errors++; $display("FAIL withdrawal got gnt=%0d en=%0d rvalid=%0d exp 0/0/0", n_dg, n_en, n_drv); end
  endtask

  task automatic test_reset_in_wait();
    if_req = 1'b1; if_addr = 32'h18;
    @(negedge clk);
    checks++; if (if_gnt !== 1'b1) begin
      errors++; $display("FAIL rw_gnt got=%b exp=1", if_gnt); end
    nxt();
    if_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL rw_busy_wait got=%b exp=1", busy); end
    nxt();
    rst = 1'b0; if_req = 1'b1; if_addr = 32'h4;
    @(negedge clk);
    checks++; if ({if_rvalid, busy, if_gnt} !== 3'b001 || if_rdata !== 32'h0 || mem_addr !== 32'h4) begin
      errors++; $display("FAIL rw_after got=%b rdata=%h addr=%h exp=001 0 4",
                         {if_rvalid, busy, if_gnt}, if_rdata, mem_addr); end
    nxt();
    if_req = 1'b0;
    for (int t = 3; t <= 5; t++) begin
      @(negedge clk);
      checks++; if (if_rvalid !== (t == 5)) begin
        errors++; $display("FAIL rw_rvalid_t%0d got=%b exp=%b", t, if_rvalid, (t == 5)); end
      if (t == 5) begin
        checks++; if (if_rdata !== init_word(1)) begin
          errors++; $display("FAIL rw_rdata got=%h exp=%h", if_rdata, init_word(1)); end
      end
      nxt();
    end
  endtask

  task automatic test_lat1();
    logic [5:0] e_gnt, e_rv, e_busy;
    logic [31:0] e_rdata;
    e_gnt = 6'b001001; e_rv = 6'b100100; e_busy = 6'b110110;
    l1_if_req = 1'b1; l1_if_addr = 32'h0;
    for (int t = 0; t <= 5; t++) begin
      if (t == 1) l1_if_addr = 32'h4;
      if (t == 4) l1_if_req = 1'b0;
      @(negedge clk);
      checks++; if ({l1_if_gnt, l1_if_rvalid, l1_busy} !== {e_gnt[t], e_rv[t], e_busy[t]}) begin
        errors++; $display("FAIL lat1_t%0d got=%b exp=%b", t, {l1_if_gnt, l1_if_rvalid, l1_busy},
                           {e_gnt[t], e_rv[t], e_busy[t]}); end
      if (t == 3) begin
        checks++; if (l1_mem_addr !== 32'h4) begin
          errors++; $display("FAIL lat1_addr got=%h exp=00000004", l1_mem_addr); end
      end
      if (t == 2 || t == 5) begin
        e_rdata = (t == 2) ? init_word(0) : init_word(1);
        checks++; if (l1_if_rdata !== e_rdata) begin
          errors++; $display("FAIL lat1_rdata_t%0d got=%h exp=%h", t, l1_if_rdata, e_rdata); end
      end
      nxt();
    end
  endtask

  task automatic test_random();
    logic [31:0] m_mem [0:255];
    int next_free, starve, p_cyc;
    bit p_valid, p_is_d, p_we, e_ig, e_dg, e_irv, e_drv, e_we, e_busy, mem_ok;
    logic [31:0] p_data, e_if_rdata, e_d_rdata, e_addr, e_wdata;
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    next_free = 0; starve = 0; p_valid = 1'b0; p_cyc = 0; p_is_d = 1'b0; p_we = 1'b0;
    p_data = 32'h0; e_if_rdata = init_word(1); e_d_rdata = 32'h0;
    for (int c = 0; c < 400; c++) begin
      if_req  = ($urandom_range(0, 99) < 65);
      d_req   = ($urandom_range(0, 99) < 55);
      d_we    = 1'($urandom_range(0, 1));
      if_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d_addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d_wdata = $urandom;
      @(negedge clk);
      e_ig = 1'b0; e_dg = 1'b0;
      if (c >= next_free) begin
        if (d_req && !(if_req && starve == SMAX)) e_dg = 1'b1;
        else if (if_req) e_ig = 1'b1;
      end
      e_busy = (c < next_free);
      e_irv = p_valid && (p_cyc == c) && !p_is_d;
      e_drv = p_valid && (p_cyc == c) && p_is_d;
      if (p_valid && p_cyc == c) begin
        if (!p_we && p_is_d) e_d_rdata = p_data;
        if (!p_we && !p_is_d) e_if_rdata = p_data;
        p_valid = 1'b0;
      end
      e_we    = e_dg && d_we;
      e_addr  = e_dg ? d_addr : (e_ig ? if_addr : 32'h0);
      e_wdata = e_dg ? d_wdata : 32'h0;
      checks++; if ({if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid} !==
                    {e_ig, e_dg, e_ig | e_dg, e_we, e_busy, e_irv, e_drv}) begin
        errors++; $display("FAIL rand_ctrl c=%0d got=%b exp=%b", c,
                           {if_gnt, d_gnt, mem_en, mem_we, busy, if_rvalid, d_rvalid},
                           {e_ig, e_dg, e_ig | e_dg, e_we, e_busy, e_irv, e_drv}); end
      checks++; if (mem_addr !== e_addr || mem_wdata !== e_wdata) begin
        errors++; $display("FAIL rand_bus c=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_wdata,
                           e_addr, e_wdata); end
      checks++; if (if_rdata !== e_if_rdata || d_rdata !== e_d_rdata) begin
        errors++; $display("FAIL rand_rdata c=%0d got=%h/%h exp=%h/%h", c, if_rdata, d_rdata,
                           e_if_rdata, e_d_rdata); end
      if (e_ig || e_dg) begin
        p_valid = 1'b1; p_cyc = c + LAT + 1; p_is_d = e_dg; p_we = e_we;
        p_data = m_mem[e_addr[9:2]];
        if (e_we) m_mem[e_addr[9:2]] = d_wdata;
        next_free = c + LAT + 2;
      end
      if (e_dg && if_req) starve = (starve < SMAX) ? starve + 1 : SMAX;
      else if (e_ig || !if_req) starve = 0;
      nxt();
    end
    idle_inputs();
    for (int k = 0; k < LAT + 3; k++) nxt();
    mem_ok = 1'b1;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) mem_ok = 1'b0;
    checks++; if (!mem_ok) begin
      errors++; $display("FAIL rand_mem_image got=differs exp=identical"); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store_then_load();
    test_starvation();
    test_withdrawal();
    test_reset_in_wait();
    test_lat1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
